// File: rtl/program_loader.sv
// Packs a received byte stream into big-endian instruction words and writes them into instruction memory.
// Optional checksum stage enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned          LENGTH    = 32,
    parameter int unsigned          MEM_DEPTH = 64,
    parameter logic [LENGTH-1:0]    HALT_WORD = LENGTH'(32'hFFFF_FFFF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              reload,
    output logic [LENGTH-1:0] instruction_to_write,
    output logic [LENGTH-1:0] address_to_write,
    output logic              write_enable,
    output logic              start,
    output logic              loading,
    output logic [LENGTH-1:0] word_count,
    output logic              checksum_error
);

    localparam int unsigned       BYTE_W    = 8;
    localparam int unsigned       CNT_W     = 2;
    localparam logic [LENGTH-1:0] LAST_ADDR = LENGTH'(MEM_DEPTH - 1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        ERROR = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1
    } state_t;
`endif

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      byte_cnt;
    logic [LENGTH-1:0]     shift_reg;
    logic [LENGTH-1:0]     packed_word_c;
    logic                  terminate_c;
    logic                  accept_c;
    logic                  word_done_c;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]     xor_sum;
    logic                  sum_match_c;
`endif

    assign packed_word_c = {shift_reg[LENGTH-BYTE_W-1:0], rx_data};

    // Load ends on the cycle its final word is presented to memory.
    always_comb begin
        terminate_c = 1'b0;
        accept_c    = 1'b0;
        word_done_c = 1'b0;
        if (state == LOAD && write_enable &&
            (instruction_to_write == HALT_WORD || address_to_write == LAST_ADDR)) begin
            terminate_c = 1'b1;
        end
        if (state == LOAD && rx_valid && !reload && !terminate_c) begin
            accept_c = 1'b1;
        end
        if (accept_c && byte_cnt == CNT_W'(3)) begin
            word_done_c = 1'b1;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign sum_match_c = (rx_data == xor_sum);
`endif

    // Next-state logic; a byte arriving in the terminating cycle is the checksum byte.
    always_comb begin
        next_state = state;
        if (reload) begin
            next_state = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (terminate_c) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        if (rx_valid) begin
                            next_state = sum_match_c ? RUN : ERROR;
                        end else begin
                            next_state = CHECK;
                        end
`else
                        next_state = RUN;
`endif
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (rx_valid) begin
                        next_state = sum_match_c ? RUN : ERROR;
                    end
                end
                ERROR:   next_state = ERROR;
`endif
                RUN:     next_state = RUN;
                default: next_state = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Registered status outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            write_enable <= 1'b0;
            start        <= 1'b0;
            loading      <= 1'b1;
        end else begin
            write_enable <= word_done_c;
            start        <= (next_state == RUN);
            loading      <= (next_state == LOAD);
        end
    end

    // Byte packing, write pointer and write payload.
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt             <= '0;
            shift_reg            <= '0;
            instruction_to_write <= '0;
            address_to_write     <= '0;
            word_count           <= '0;
        end else if (reload) begin
            byte_cnt   <= '0;
            shift_reg  <= '0;
            word_count <= '0;
        end else if (accept_c) begin
            byte_cnt  <= byte_cnt + CNT_W'(1);
            shift_reg <= packed_word_c;
            if (word_done_c) begin
                instruction_to_write <= packed_word_c;
                address_to_write     <= word_count;
                word_count           <= word_count + LENGTH'(1);
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running XOR over every accepted instruction byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            xor_sum        <= '0;
            checksum_error <= 1'b0;
        end else begin
            checksum_error <= (next_state == ERROR);
            if (reload) begin
                xor_sum <= '0;
            end else if (accept_c) begin
                xor_sum <= xor_sum ^ rx_data;
            end
        end
    end
`else
    assign checksum_error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Table-driven bench for program_loader: per-cycle input vectors with hand-computed expected outputs.
module tb_program_loader;

    typedef struct {
        logic        sel;
        logic        rst_n;
        logic        rv;
        logic [7:0]  rd;
        logic        rl;
        logic        we;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        st;
        logic        ld;
        logic [31:0] wc;
        logic        ce;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        reload = 1'b0;

    logic [31:0] b_instr, b_addr, b_wc;
    logic        b_we, b_st, b_ld, b_ce;
    logic [31:0] s_instr, s_addr, s_wc;
    logic        s_we, s_st, s_ld, s_ce;

    vec_t        vecs[$];
    logic        cur_sel;
    int          applied = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    program_loader u_dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .reload(reload),
        .instruction_to_write(b_instr), .address_to_write(b_addr), .write_enable(b_we),
        .start(b_st), .loading(b_ld), .word_count(b_wc), .checksum_error(b_ce)
    );

    program_loader #(.MEM_DEPTH(4)) u_small (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .reload(reload),
        .instruction_to_write(s_instr), .address_to_write(s_addr), .write_enable(s_we),
        .start(s_st), .loading(s_ld), .word_count(s_wc), .checksum_error(s_ce)
    );

    task automatic row(input logic rst_n, input logic rv, input logic [7:0] rd, input logic rl,
                       input logic we, input logic [31:0] instr, input logic [31:0] addr,
                       input logic st, input logic ld, input logic [31:0] wc, input logic ce);
        vec_t v;
        v.sel = cur_sel; v.rst_n = rst_n; v.rv = rv; v.rd = rd; v.rl = rl;
        v.we = we; v.instr = instr; v.addr = addr; v.st = st; v.ld = ld; v.wc = wc; v.ce = ce;
        vecs.push_back(v);
    endtask

    task automatic check(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    initial begin
        // Main DUT: first word, back-to-back words, halt, RUN, reload cases.
        cur_sel = 1'b0;
        row(0,0,8'h00,0, 0,32'h0,32'h0, 0,1,0,0);
        row(0,0,8'h00,0, 0,32'h0,32'h0, 0,1,0,0);
        row(1,1,8'h8C,0, 0,0,0, 0,1,0,0);
        row(1,1,8'h01,0, 0,0,0, 0,1,0,0);
        row(1,1,8'h00,0, 0,0,0, 0,1,0,0);
        row(1,1,8'h04,0, 1,32'h8C010004,32'd0, 0,1,1,0);
        row(1,0,8'h00,0, 0,0,0, 0,1,1,0);
        row(1,1,8'h11,0, 0,0,0, 0,1,1,0);
        row(1,1,8'h22,0, 0,0,0, 0,1,1,0);
        row(1,1,8'h33,0, 0,0,0, 0,1,1,0);
        row(1,1,8'h44,0, 1,32'h11223344,32'd1, 0,1,2,0);
        row(1,1,8'h55,0, 0,0,0, 0,1,2,0);
        row(1,1,8'h66,0, 0,0,0, 0,1,2,0);
        row(1,1,8'h77,0, 0,0,0, 0,1,2,0);
        row(1,1,8'h88,0, 1,32'h55667788,32'd2, 0,1,3,0);
        row(1,0,8'h00,0, 0,0,0, 0,1,3,0);
        row(1,1,8'hFF,0, 0,0,0, 0,1,3,0);
        row(1,1,8'hFF,0, 0,0,0, 0,1,3,0);
        row(1,1,8'hFF,0, 0,0,0, 0,1,3,0);
        row(1,1,8'hFF,0, 1,32'hFFFFFFFF,32'd3, 0,1,4,0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        row(1,0,8'h00,0, 0,0,0, 0,0,4,0);
        row(1,1,8'h01,0, 0,0,0, 1,0,4,0);
`else
        row(1,0,8'h00,0, 0,0,0, 1,0,4,0);
`endif
        row(1,1,8'h01,0, 0,0,0, 1,0,4,0);
        row(1,1,8'h02,0, 0,0,0, 1,0,4,0);
        row(1,1,8'h03,0, 0,0,0, 1,0,4,0);
        row(1,1,8'h04,0, 0,0,0, 1,0,4,0);
        row(1,0,8'h00,0, 0,0,0, 1,0,4,0);
        row(1,1,8'h5A,1, 0,0,0, 0,1,0,0);
        row(1,1,8'hAA,0, 0,0,0, 0,1,0,0);
        row(1,1,8'hBB,0, 0,0,0, 0,1,0,0);
        row(1,1,8'hCC,1, 0,0,0, 0,1,0,0);
        row(1,1,8'h00,0, 0,0,0, 0,1,0,0);
        row(1,1,8'h00,0, 0,0,0, 0,1,0,0);
        row(1,1,8'h00,0, 0,0,0, 0,1,0,0);
        row(1,1,8'h01,0, 1,32'h00000001,32'd0, 0,1,1,0);
        row(1,0,8'h00,0, 0,0,0, 0,1,1,0);

        // Small-memory DUT: five words, only four fit.
        cur_sel = 1'b1;
        row(0,0,8'h00,0, 0,32'h0,32'h0, 0,1,0,0);
        for (int w = 1; w <= 4; w++) begin
            for (int b = 0; b < 3; b++) row(1,1,8'(w),0, 0,0,0, 0,1,32'(w-1),0);
            row(1,1,8'(w),0, 1,{4{8'(w)}},32'(w-1), 0,1,32'(w),0);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        row(1,0,8'h00,0, 0,0,0, 0,0,4,0);
        row(1,1,8'h00,0, 0,0,0, 1,0,4,0);
`endif
        for (int b = 0; b < 4; b++) row(1,1,8'h05,0, 0,0,0, 1,0,4,0);
        row(1,0,8'h00,0, 0,0,0, 1,0,4,0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Checksum pass then fail, each cleared by reset.
        cur_sel = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            row(0,0,8'h00,0, 0,32'h0,32'h0, 0,1,0,0);
            row(1,1,8'h01,0, 0,0,0, 0,1,0,0);
            row(1,1,8'h02,0, 0,0,0, 0,1,0,0);
            row(1,1,8'h03,0, 0,0,0, 0,1,0,0);
            row(1,1,8'h04,0, 1,32'h01020304,32'd0, 0,1,1,0);
            for (int b = 0; b < 3; b++) row(1,1,8'hFF,0, 0,0,0, 0,1,1,0);
            row(1,1,8'hFF,0, 1,32'hFFFFFFFF,32'd1, 0,1,2,0);
            row(1,0,8'h00,0, 0,0,0, 0,0,2,0);
            if (pass == 0) row(1,1,8'h04,0, 0,0,0, 1,0,2,0);
            else           row(1,1,8'h05,0, 0,0,0, 0,0,2,1);
            row(1,0,8'h00,0, 0,0,0, pass == 0 ? 1'b1 : 1'b0, 0, 2, pass == 0 ? 1'b0 : 1'b1);
        end
        row(0,0,8'h00,0, 0,32'h0,32'h0, 0,1,0,0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [31:0] a_instr, a_addr, a_wc;
            logic        a_we, a_st, a_ld, a_ce;
            v = vecs[i];
            reset = v.rst_n; rx_valid = v.rv; rx_data = v.rd; reload = v.rl;
            @(posedge clk);
            #1;
            if (v.sel) begin
                a_instr = s_instr; a_addr = s_addr; a_wc = s_wc;
                a_we = s_we; a_st = s_st; a_ld = s_ld; a_ce = s_ce;
            end else begin
                a_instr = b_instr; a_addr = b_addr; a_wc = b_wc;
                a_we = b_we; a_st = b_st; a_ld = b_ld; a_ce = b_ce;
            end
            applied++;
            check(i, "write_enable", 32'(a_we), 32'(v.we));
            check(i, "start", 32'(a_st), 32'(v.st));
            check(i, "loading", 32'(a_ld), 32'(v.ld));
            check(i, "word_count", a_wc, v.wc);
            check(i, "checksum_error", 32'(a_ce), 32'(v.ce));
            if (v.we || !v.rst_n) begin
                check(i, "instruction_to_write", a_instr, v.instr);
                check(i, "address_to_write", a_addr, v.addr);
            end
        end
        rx_valid = 1'b0;
        reload = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
